calc_seq_ctrl: RTL and testbench

- Command sequencer between the I2C slave byte interface and the calculator ALU inside the I2C calculator top.
- Collects opcode and operands A and B from written bytes, then launches the multi-cycle ALU and waits for completion.
- Latches the result and status and serves them back on I2C read requests as status, result-hi, result-lo.

---
 rtl/calc_pkg.sv | 51 +++++
 rtl/calc_seq_ctrl_readback.sv | 58 +++++
 rtl/calc_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_calc_seq_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the I2C calculator command sequencer.
// Opcode and FSM enums, status bit positions, read-pointer encodings.
package calc_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_SHL = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_A  = 3'd1,
        ST_GET_B  = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RP_STAT = 2'd0,
        RP_HI   = 2'd1,
        RP_LO   = 2'd2
    } rp_e;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_OVR     = 3;
    localparam int STAT_ABORT   = 4;
    localparam int STAT_TIMEOUT = 5;

    function automatic logic [7:0] pack_status(input logic busy, input logic done,
                                               input logic err, input logic ovr,
                                               input logic abort, input logic timeout);
        logic [7:0] s;
        s = '0;
        s[STAT_BUSY]    = busy;
        s[STAT_DONE]    = done;
        s[STAT_ERR]     = err;
        s[STAT_OVR]     = ovr;
        s[STAT_ABORT]   = abort;
        s[STAT_TIMEOUT] = timeout;
        return s;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_readback.sv
// Read-back path: status / result-hi / result-lo pointer with registered output
// and a strobe telling the sequencer that the status byte has just been served.
module calc_readback_mux
    import calc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RES_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              xfer_stop,
    input  logic [DATA_W-1:0] status,
    input  logic [RES_W-1:0]  result,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stat_clr
);

    rp_e               ptr;
    logic [DATA_W-1:0] sel_byte;

    always_comb begin
        sel_byte = '0;
        unique case (ptr)
            RP_STAT: sel_byte = status;
            RP_HI:   sel_byte = result[RES_W-1:DATA_W];
            RP_LO:   sel_byte = result[DATA_W-1:0];
            default: sel_byte = '0;
        endcase
    end

    // The status byte is captured with its pre-clear value; the clear lands on the same edge.
    assign stat_clr = rd_req && (ptr == RP_STAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= RP_STAT;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= sel_byte;
            end
            if (xfer_stop) begin
                ptr <= RP_STAT;
            end else if (rd_req) begin
                unique case (ptr)
                    RP_STAT: ptr <= RP_HI;
                    RP_HI:   ptr <= RP_LO;
                    default: ptr <= RP_STAT;
                endcase
            end
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Command sequencer between the I2C slave byte interface and the calculator ALU.
// Optional ALU watchdog is compiled in with `define CALC_SEQ_TIMEOUT_EN.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int RES_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              xfer_stop,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  alu_result,
    input  logic              alu_err,
    output logic              busy
);

    // Handshake: wr_valid, rd_req, xfer_stop and alu_done are single-cycle pulses with no
    // back-pressure; every pulse is consumed on the edge it is seen or dropped by rule.

    state_e            state, state_nxt, byte_nxt;
    op_e               op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [RES_W-1:0]  result_q;
    logic              done_q, err_q, ovr_q, abort_q, timeout_q;
    logic              opcode_ok, abort_set, wait_done, tmo_hit, stat_clr;
    logic [DATA_W-1:0] status;

    assign opcode_ok = (wr_data[DATA_W-1:3] == '0);
    assign wait_done = (state == ST_WAIT) && alu_done;

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign tmo_hit = (state == ST_WAIT) && !alu_done && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYC;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        byte_nxt  = state;
        alu_start = 1'b0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE:   if (wr_valid && opcode_ok) byte_nxt = ST_GET_A;
            ST_GET_A:  if (wr_valid) byte_nxt = ST_GET_B;
            ST_GET_B:  if (wr_valid) byte_nxt = ST_LAUNCH;
            ST_LAUNCH: begin
                byte_nxt  = ST_WAIT;
                alu_start = 1'b1;
                busy      = 1'b1;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (alu_done || tmo_hit) byte_nxt = ST_IDLE;
            end
            default:   byte_nxt = ST_IDLE;
        endcase
        // A stop is applied after the same-cycle byte, so it aborts only a half-collected command.
        abort_set = xfer_stop && (byte_nxt == ST_GET_A || byte_nxt == ST_GET_B);
        state_nxt = abort_set ? ST_IDLE : byte_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ovr_q     <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Clear-on-read first so that a sticky event in the same cycle survives.
            if (stat_clr) begin
                ovr_q     <= 1'b0;
                abort_q   <= 1'b0;
                timeout_q <= 1'b0;
            end
            if (wr_valid && busy) ovr_q <= 1'b1;
            if (abort_set) abort_q <= 1'b1;
            if (state == ST_IDLE && wr_valid) begin
                if (opcode_ok) op_q <= op_e'(wr_data[2:0]);
                else err_q <= 1'b1;
            end
            if (state == ST_GET_A && wr_valid) a_q <= wr_data;
            if (state == ST_GET_B && wr_valid) begin
                b_q    <= wr_data;
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (wait_done) begin
                result_q <= alu_result;
                err_q    <= alu_err;
                done_q   <= 1'b1;
            end else if (tmo_hit) begin
                result_q  <= '1;
                err_q     <= 1'b1;
                done_q    <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign status = pack_status(busy, done_q, err_q, ovr_q, abort_q, timeout_q);

    calc_readback_mux #(
        .DATA_W (DATA_W),
        .RES_W  (RES_W)
    ) u_readback (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .xfer_stop (xfer_stop),
        .status    (status),
        .result    (result_q),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .stat_clr  (stat_clr)
    );

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed scenarios plus random traffic against a
// transaction-level model of the command/status behaviour.
module tb_calc_seq_ctrl;

    localparam int TMO = 16;

    logic        clk, rst;
    logic        wr_valid, rd_req, xfer_stop, alu_done, alu_err;
    logic [7:0]  wr_data, rd_data, alu_a, alu_b;
    logic        rd_valid, alu_start, busy;
    logic [2:0]  alu_op;
    logic [15:0] alu_result;

    int n_cmp = 0;
    int n_fail = 0;

    calc_seq_ctrl #(.DATA_W(8), .RES_W(16), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .xfer_stop(xfer_stop),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err), .busy(busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  exp_q[$];
    logic [18:0] launch_q[$];
    int          m_cnt, m_rp, m_wait_cyc;
    bit          m_busy, m_done, m_err, m_ovr, m_abort, m_tmo, m_just, m_launch_now;
    logic [7:0]  m_op, m_a, m_b;
    logic [15:0] m_res;
    bit          ovr_en;
    logic [16:0] ovr_val;

    function automatic logic [16:0] alu_calc(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op[2:0])
            3'd0: return {1'b0, 16'(a) + 16'(b)};
            3'd1: return {1'b0, 16'(a) - 16'(b)};
            3'd2: return {1'b0, 16'(a) * 16'(b)};
            3'd3: return (b == 8'd0) ? {1'b1, 16'h0000} : {1'b0, 16'(a / b)};
            3'd4: return {9'd0, a & b};
            3'd5: return {9'd0, a | b};
            3'd6: return {9'd0, a ^ b};
            default: return {1'b0, 16'(a) << b[3:0]};
        endcase
    endfunction

    function automatic void m_reset();
        m_cnt = 0; m_rp = 0; m_wait_cyc = 0;
        m_busy = 0; m_done = 0; m_err = 0; m_ovr = 0; m_abort = 0; m_tmo = 0; m_just = 0;
        m_op = 0; m_a = 0; m_b = 0; m_res = 0;
        exp_q.delete();
        launch_q.delete();
    endfunction

    function automatic void m_read();
        logic [7:0] e;
        if (m_rp == 0) e = {2'b00, m_tmo, m_abort, m_ovr, m_err, m_done, m_busy};
        else if (m_rp == 1) e = m_res[15:8];
        else e = m_res[7:0];
        if (m_rp == 0) begin m_ovr = 0; m_abort = 0; m_tmo = 0; end
        m_rp = (m_rp + 1) % 3;
        exp_q.push_back(e);
    endfunction

    function automatic void m_write(input logic [7:0] b);
        if (m_busy) m_ovr = 1;
        else if (m_cnt == 0) begin
            if (b > 8'd7) m_err = 1;
            else begin m_op = b; m_cnt = 1; end
        end else if (m_cnt == 1) begin
            m_a = b; m_cnt = 2;
        end else begin
            m_b = b; m_cnt = 0; m_busy = 1; m_done = 0; m_err = 0; m_wait_cyc = 0;
            m_launch_now = 1;
            launch_q.push_back({m_op[2:0], m_a, m_b});
        end
    endfunction

    function automatic void m_stop();
        if (m_cnt != 0) begin m_abort = 1; m_cnt = 0; end
        m_rp = 0;
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input bit wr, input logic [7:0] wb, input bit rd, input bit stp, input bit dn);
        bit in_wait;
        logic [16:0] r;
        in_wait = m_busy && !m_just;
        r = ovr_en ? ovr_val : alu_calc(m_op, m_a, m_b);
        wr_valid = wr; wr_data = wb; rd_req = rd; xfer_stop = stp;
        alu_done = dn; alu_result = r[15:0]; alu_err = r[16];
        m_launch_now = 0;
        if (rd) m_read();
        if (wr) m_write(wb);
        if (stp) m_stop();
        if (in_wait) begin
            m_wait_cyc++;
            if (dn) begin
                m_res = r[15:0]; m_err = r[16]; m_done = 1; m_busy = 0;
            end
`ifdef CALC_SEQ_TIMEOUT_EN
            else if (m_wait_cyc == TMO) begin
                m_res = 16'hFFFF; m_err = 1; m_done = 1; m_tmo = 1; m_busy = 0;
            end
`endif
        end
        m_just = m_launch_now;
        @(negedge clk);
        wr_valid = 0; rd_req = 0; xfer_stop = 0; alu_done = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; wr_valid = 0; wr_data = 0; rd_req = 0; xfer_stop = 0;
        alu_done = 0; alu_result = 0; alu_err = 0; ovr_en = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        m_reset();
    endtask

    task automatic read3();
        cycle(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 0, 0);
    endtask

    // ---------------- scoreboard / monitors ----------------
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got rd_data=%h with no read expected", rd_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
        if (!rst && alu_start) begin
            n_cmp++;
            if (launch_q.size() == 0) begin
                n_fail++;
                $display("FAIL alu_start_unexpected: got op=%0d a=%h b=%h with no launch expected", alu_op, alu_a, alu_b);
            end else begin
                logic [18:0] l;
                l = launch_q.pop_front();
                if ({alu_op, alu_a, alu_b} !== l) begin
                    n_fail++;
                    $display("FAIL alu_launch: got %h expected %h", {alu_op, alu_a, alu_b}, l);
                end
            end
        end
    end

    task automatic test_end(input string name);
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0 || launch_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got pending reads=%0d launches=%0d expected 0/0", name, exp_q.size(), launch_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rd_data, rd_valid, alu_op, alu_a, alu_b, alu_start, busy} !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {rd_data, rd_valid, alu_op, alu_a, alu_b, alu_start, busy});
        end
        read3();
        test_end("reset");
    endtask

    task automatic test_add();
        do_reset();
        cycle(1, 8'h00, 0, 0, 0);
        cycle(1, 8'h12, 0, 0, 0);
        cycle(1, 8'h34, 0, 0, 0);
        n_cmp++;
        if ({alu_start, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL add_start: got start/busy=%b expected 11", {alu_start, busy});
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h00, 0, 0, 0);
            n_cmp++;
            if ({alu_start, busy, alu_op, alu_a, alu_b} !== {2'b01, 3'd0, 8'h12, 8'h34}) begin
                n_fail++;
                $display("FAIL add_hold: got %h expected %h", {alu_start, busy, alu_op, alu_a, alu_b}, {2'b01, 3'd0, 8'h12, 8'h34});
            end
        end
        cycle(0, 8'h00, 0, 0, 1);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL add_busy_fall: got %b expected 0", busy);
        end
        read3();
        test_end("add");
    endtask

    task automatic test_div_zero();
        do_reset();
        cycle(1, 8'h03, 0, 0, 0);
        cycle(1, 8'h10, 0, 0, 0);
        cycle(1, 8'h00, 0, 0, 0);
        idle(3);
        cycle(0, 8'h00, 0, 0, 1);
        read3();
        test_end("div_zero");
    endtask

    task automatic test_bad_opcode();
        do_reset();
        cycle(1, 8'h80, 0, 1, 0);
        read3();
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(1, 8'h00, 0, 0, 0);
        cycle(1, 8'h01, 0, 0, 0);
        cycle(1, 8'h02, 0, 0, 0);
        idle(1);
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 0, 1);
        test_end("bad_opcode");
    endtask

    task automatic test_abort();
        do_reset();
        cycle(1, 8'h02, 0, 0, 0);
        cycle(1, 8'h05, 0, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 1, 0, 0);
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 1, 0, 0);
        // Stop together with the A byte: A is taken, then the command is aborted.
        cycle(1, 8'h01, 0, 0, 0);
        cycle(1, 8'h07, 0, 1, 0);
        cycle(0, 8'h00, 1, 0, 0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b expected 0", busy);
        end
        test_end("abort");
    endtask

    task automatic test_overrun();
        do_reset();
        ovr_en = 1; ovr_val = {1'b0, 16'h000C};
        cycle(1, 8'h01, 0, 0, 0);
        cycle(1, 8'h03, 0, 0, 0);
        cycle(1, 8'h04, 0, 0, 0);
        idle(1);
        cycle(1, 8'hA5, 0, 0, 0);
        cycle(1, 8'h5A, 0, 0, 0);
        cycle(0, 8'h00, 0, 0, 1);
        read3();
        cycle(0, 8'h00, 0, 1, 0);
        cycle(0, 8'h00, 1, 0, 0);
        ovr_en = 0;
        test_end("overrun");
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        cycle(1, 8'h02, 0, 0, 0);
        cycle(1, 8'h09, 0, 0, 0);
        cycle(1, 8'h07, 0, 0, 0);
        idle(3);
        rst = 1;
        @(negedge clk);
        rst = 0;
        m_reset();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwait_busy: got %b expected 0", busy);
        end
        cycle(0, 8'h00, 0, 0, 1);
        read3();
        test_end("reset_mid_wait");
    endtask

`ifdef CALC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        cycle(1, 8'h05, 0, 0, 0);
        cycle(1, 8'h02, 0, 0, 0);
        cycle(1, 8'h03, 0, 0, 0);
        idle(1);
        idle(15);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_busy_hold: got %b expected 1", busy);
        end
        idle(1);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_busy_fall: got %b expected 0", busy);
        end
        read3();
        test_end("timeout");
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit wr, rd, stp, dn;
            logic [7:0] wb;
            wr  = ($urandom_range(0, 1) == 1);
            rd  = ($urandom_range(0, 9) < 3);
            stp = ($urandom_range(0, 11) == 0);
            dn  = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
            if (!m_busy && m_cnt == 0)
                wb = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            else
                wb = 8'($urandom_range(0, 255));
            cycle(wr, wb, rd, stp, dn);
        end
        if (m_busy) begin
            idle(1);
            cycle(0, 8'h00, 0, 0, 1);
        end
        read3();
        test_end("random");
    endtask

    initial begin
        test_reset();
        test_add();
        test_div_zero();
        test_bad_opcode();
        test_abort();
        test_overrun();
        test_reset_mid_wait();
`ifdef CALC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
